fir_sample_scheduler: RTL and testbench
=======================================

# fir_sample_scheduler

Front-end and back-end sequencer for the 4-tap time-multiplexed FIR core. Accepts input samples over a valid/ready stream and buffers them in a small FIFO. Issues `load` pulses to the core exactly when the core's controller can accept them, mirroring its 4-cycle schedule. Captures each filter result on the core's `valid_out` and presents it downstream over a valid/ready stream, with credit-based backpressure so that a result is never dropped.

## Interface
- `DATA_W`, 8: input sample width.
- `OUT_W`, 18: FIR result width.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high. Must also drive the core's reset, inverted at top level.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: FIFO can accept.
- `in_data` in DATA_W: upstream sample.
- `core_load` out 1: load pulse to the FIR core controller.
- `core_sample` out DATA_W: sample to the core shift register, valid when `core_load`=1.
- `core_valid` in 1: core `valid_out`.
- `core_y` in OUT_W: core accumulator output.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts.
- `out_data` out OUT_W: result.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `busy` out 1: state≠IDLE, or FIFO non-empty, or output buffer non-empty.
- `seq_err` out 1: sticky protocol error; cleared only by reset.

## Operation
- **Input FIFO.**
  - Push when `in_valid && in_ready`.
  - `in_ready` = !rst && (level < FIFO_DEPTH), decoded from the registered level.
  - Pop when `core_load`=1.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `core_sample` = FIFO head (registered storage). Drives 0 when the FIFO is empty.
- **Phase FSM mirroring the core.** States are IDLE, P1, P2, P3, P4.
  - IDLE: go to P1 if `core_load`, else stay in IDLE.
  - P1 → P2 → P3 → P4 unconditionally.
  - P4: go to P1 if `core_load`, else go to IDLE.
- **Issue rule.**
  - `core_load` = (state==IDLE || state==P4) && fifo_nonempty && (out_cnt + inflight ≤ 1).
  - `inflight` = (state≠IDLE).
  - `core_load` is combinational from registered state only. There is no path from `in_valid` or `out_ready`.
  - This rule reserves an output slot before every issue, so no result is ever lost.
- **Result capture.**
  - In P4, `core_valid` is expected to be 1. Push `core_y` into the 2-entry output buffer.
  - `core_valid`=1 in any state other than P4 sets `seq_err`, and the data is discarded.
  - `core_valid`=0 in P4 sets `seq_err`, and nothing is pushed.
- **Output buffer.**
  - 2 entries, FIFO order.
  - `out_valid` = out_cnt≠0.
  - `out_data` = head.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle are both honoured.
- **Arithmetic.**
  - `core_y` is passed through unmodified; no truncation.
  - Counters never wrap past their bounds; the issue rule and the `in_ready` rule guarantee this.

## Timing
- **Reset values.** While `rst`=1 and after its release:
  - state=IDLE; both buffers empty.
  - `in_ready`=0 during reset, 1 after release.
  - `core_load`=0, `core_sample`=0, `out_valid`=0, `out_data`=0, `fifo_level`=0, `busy`=0, `seq_err`=0.
- **Latency, FIFO empty and idle.**
  - Sample accepted at edge t.
  - `core_load`=1 in cycle t+1.
  - `core_valid` in cycle t+5 (P4).
  - `out_valid`=1 in cycle t+6.
- **Throughput.** One sample per 4 cycles. With `out_ready` held at 1, loads repeat back-to-back on every P4.
- **Backpressure.**
  - With `out_ready`=0, at most 2 results are outstanding (buffered plus in flight).
  - Issue stalls in IDLE until out_cnt + inflight ≤ 1.
- **Reset mid-operation.** All state is flushed immediately, without waiting for a clock edge. Buffered samples and results are lost, and no `seq_err` is raised.

## Test plan
- **Single sample.** Reset, then push 0x05 at t. Expect `core_load` at t+1 only, with `core_sample`=0x05; `core_valid` drive at t+5; `out_valid` at t+6 with `out_data` = the driven `core_y`; `seq_err`=0.
- **Burst.** Push 6 samples back-to-back with `out_ready`=1.
  - `in_ready` drops when the level reaches 4.
  - Loads occur at t+1, t+5, t+9, …
  - 6 results appear in order, 4 cycles apart.
- **Backpressure.** Push 4 samples with `out_ready`=0.
  - Exactly 2 loads occur; the FSM then parks in IDLE with level=2 and out_cnt=2.
  - Raise `out_ready`: both results drain, and the next load follows when out_cnt + inflight ≤ 1.
- **Protocol error.**
  - Drive `core_valid`=1 while in IDLE: `seq_err` goes to 1 and stays there.
  - Omit `core_valid` in P4: `seq_err`=1 and out_cnt is unchanged.
- **Reset mid-run.** Assert `rst` during P2 with level=3. All outputs return to their reset values asynchronously. After release, `fifo_level`=0 and `out_valid`=0.
- **Simultaneous events.** Push and pop at full FIFO (`in_ready`=0, so no push occurs) and at level=2 (push and pop together, level stays 2). Output push and pop in the same cycle leaves out_cnt unchanged.

Source files
------------

// File: rtl/fir_sample_scheduler_if.sv
// Stream and core-side signal bundle for the FIR sample scheduler.
// The scheduler connects through the slave modport; the environment uses master.
`timescale 1ns/1ps
interface fir_sample_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              core_load;
  logic [DATA_W-1:0] core_sample;
  logic              core_valid;
  logic [OUT_W-1:0]  core_y;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, core_valid, core_y, out_ready,
    input  in_ready, core_load, core_sample, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, core_valid, core_y, out_ready,
    output in_ready, core_load, core_sample, out_valid, out_data
  );
endinterface

// File: rtl/fir_sample_scheduler.sv
// Input FIFO, phase mirror of the 4-cycle FIR core schedule and a 2-entry
// result buffer whose credit check keeps every issued sample's result slot reserved.
`timescale 1ns/1ps
module fir_sample_scheduler #(
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fir_sample_scheduler_if.slave      bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                       busy,
  output logic                       seq_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [OUT_W-1:0]  obuf [2];
  logic              ohead;
  logic [1:0]        out_cnt;
  logic              push, load, fifo_nonempty, inflight, credit_ok;
  logic              cap_push, out_pop, err;

  assign fifo_nonempty   = (level != '0);
  assign bus.in_ready    = !rst && (level < LW'(FIFO_DEPTH));
  assign push            = bus.in_valid && bus.in_ready;
  assign bus.core_load   = load;
  assign bus.core_sample = fifo_nonempty ? mem[rd_ptr] : '0;
  assign fifo_level      = level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (load)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !load)
        level <= level + 1'b1;
      else if (load && !push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_data;
  end

  // An issue is allowed only if the result buffer can absorb everything already in flight plus this one.
  assign inflight  = (state != IDLE);
  assign credit_ok = ({1'b0, out_cnt} + {2'b00, inflight}) <= 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        load       = fifo_nonempty && credit_ok;
        next_state = load ? P1 : IDLE;
      end
      P1: next_state = P2;
      P2: next_state = P3;
      P3: next_state = P4;
      P4: begin
        load       = fifo_nonempty && credit_ok;
        next_state = load ? P1 : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign cap_push = (state == P4) && bus.core_valid;
  assign err      = (state == P4) ? !bus.core_valid : bus.core_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seq_err <= 1'b0;
    else if (err)
      seq_err <= 1'b1;
  end

  assign bus.out_valid = (out_cnt != 2'd0);
  assign bus.out_data  = bus.out_valid ? obuf[ohead] : '0;
  assign out_pop       = bus.out_valid && bus.out_ready;

  // Tail slot is head xor count parity; a push into a full buffer only happens alongside a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf[0] <= '0;
      obuf[1] <= '0;
      ohead   <= 1'b0;
      out_cnt <= 2'd0;
    end else begin
      if (cap_push)
        obuf[ohead ^ out_cnt[0]] <= bus.core_y;
      if (out_pop)
        ohead <= ~ohead;
      case ({cap_push, out_pop})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign busy = (state != IDLE) || fifo_nonempty || (out_cnt != 2'd0);
endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Directed bench for fir_sample_scheduler with a behavioural 4-cycle FIR core
// model that answers each load with core_y = 0x20000 + 5*sample.
`timescale 1ns/1ps
module tb_fir_sample_scheduler;
  localparam int DATA_W     = 8;
  localparam int OUT_W      = 18;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_level;
  logic       busy;
  logic       seq_err;
  logic       core_en = 1'b1;
  logic       inject  = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int acc_q[$], load_q[$], smp_q[$], cv_q[$], out_q[$], dat_q[$];
  int lvl4_seen, lvl4_ready;

  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  fir_sample_scheduler_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  fir_sample_scheduler #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fifo_level(fifo_level),
    .busy(busy),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] coreY(input logic [7:0] s);
    return 18'h20000 + 18'(s) * 18'd5;
  endfunction

  function automatic int qAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearLogs();
    acc_q.delete(); load_q.delete(); smp_q.delete();
    cv_q.delete();  out_q.delete();  dat_q.delete();
    lvl4_seen  = 0;
    lvl4_ready = 0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50)
      checkOutput("push_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Core model: a load seen in cycle L produces core_valid/core_y during cycle L+4.
  initial begin
    logic [3:0] vpipe;
    logic [7:0] spipe [4];
    logic       ld;
    logic [7:0] smp;
    vpipe = '0;
    for (int i = 0; i < 4; i++) spipe[i] = '0;
    bus.core_valid = 1'b0;
    bus.core_y     = '0;
    forever begin
      @(negedge clk);
      ld  = bus.core_load;
      smp = bus.core_sample;
      @(posedge clk);
      #1;
      if (rst) begin
        vpipe = '0;
      end else begin
        vpipe    = {vpipe[2:0], ld};
        spipe[3] = spipe[2];
        spipe[2] = spipe[1];
        spipe[1] = spipe[0];
        spipe[0] = smp;
      end
      bus.core_valid = (vpipe[3] && core_en) || inject;
      bus.core_y     = vpipe[3] ? coreY(spipe[3]) : 18'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.core_load) begin
        load_q.push_back(cyc);
        smp_q.push_back(int'(bus.core_sample));
      end
      if (bus.core_valid) cv_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(cyc);
        dat_q.push_back(int'(bus.out_data));
      end
      if (fifo_level == 3'd4) begin
        lvl4_seen++;
        if (bus.in_ready) lvl4_ready++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, r, l2, n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    clearLogs();
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_in_ready",    32'(bus.in_ready),    32'd0);
    checkOutput("rst_core_load",   32'(bus.core_load),   32'd0);
    checkOutput("rst_core_sample", 32'(bus.core_sample), 32'd0);
    checkOutput("rst_out_valid",   32'(bus.out_valid),   32'd0);
    checkOutput("rst_out_data",    32'(bus.out_data),    32'd0);
    checkOutput("rst_fifo_level",  32'(fifo_level),      32'd0);
    checkOutput("rst_busy",        32'(busy),            32'd0);
    checkOutput("rst_seq_err",     32'(seq_err),         32'd0);
    rst = 1'b0;
    tick();
    checkOutput("rel_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rel_busy",     32'(busy),         32'd0);

    $display("[TB] single sample");
    clearLogs();
    applyStimulus(8'h05);
    repeat (12) tick();
    t = qAt(acc_q, 0);
    checkOutput("single_loads",    32'(load_q.size()),   32'd1);
    checkOutput("single_load_cyc", qAt(load_q, 0),       t + 1);
    checkOutput("single_sample",   qAt(smp_q, 0),        32'h05);
    checkOutput("single_cv_cyc",   qAt(cv_q, 0),         t + 5);
    checkOutput("single_out_cyc",  qAt(out_q, 0),        t + 6);
    checkOutput("single_out_data", qAt(dat_q, 0),        32'h20019);
    checkOutput("single_outs",     32'(out_q.size()),    32'd1);
    checkOutput("single_seq_err",  32'(seq_err),         32'd0);
    checkOutput("single_idle",     32'(busy),            32'd0);

    $display("[TB] burst");
    clearLogs();
    for (int i = 0; i < 6; i++) applyStimulus(burst[i]);
    repeat (40) tick();
    t = qAt(acc_q, 0);
    checkOutput("burst_loads",     32'(load_q.size()), 32'd6);
    checkOutput("burst_outs",      32'(out_q.size()),  32'd6);
    checkOutput("burst_lvl4_seen", 32'(lvl4_seen > 0), 32'd1);
    checkOutput("burst_lvl4_rdy",  lvl4_ready,         32'd0);
    checkOutput("burst_first_ld",  qAt(load_q, 0),     t + 1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("burst_sample", qAt(smp_q, i), 32'(burst[i]));
      checkOutput("burst_data",   qAt(dat_q, i), 32'(coreY(burst[i])));
      if (i > 0) begin
        checkOutput("burst_load_gap", qAt(load_q, i) - qAt(load_q, i - 1), 32'd4);
        checkOutput("burst_out_gap",  qAt(out_q, i) - qAt(out_q, i - 1),   32'd4);
      end
    end
    checkOutput("burst_seq_err", 32'(seq_err), 32'd0);

    $display("[TB] backpressure");
    clearLogs();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i));
    repeat (20) tick();
    checkOutput("bp_loads_parked", 32'(load_q.size()),  32'd2);
    checkOutput("bp_level_parked", 32'(fifo_level),     32'd2);
    checkOutput("bp_out_valid",    32'(bus.out_valid),  32'd1);
    checkOutput("bp_out_head",     32'(bus.out_data),   32'(coreY(8'hA0)));
    checkOutput("bp_busy",         32'(busy),           32'd1);
    r = cyc;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA4;
    checkOutput("bp_level_r1",  32'(fifo_level),   32'd2);
    checkOutput("bp_out_head2", 32'(bus.out_data), 32'(coreY(8'hA1)));
    tick();
    bus.in_valid = 1'b0;
    checkOutput("bp_level_pushpop", 32'(fifo_level), 32'd2);
    checkOutput("bp_resume_cyc",    qAt(load_q, 2),   r + 1);
    checkOutput("bp_resume_sample", qAt(smp_q, 2),    32'hA2);
    repeat (3) tick();
    bus.out_ready = 1'b1;
    checkOutput("bp_p4_core_valid", 32'(bus.core_valid), 32'd1);
    checkOutput("bp_p4_head",       32'(bus.out_data),   32'(coreY(8'hA1)));
    tick();
    checkOutput("bp_sim_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_sim_out_data",  32'(bus.out_data),  32'(coreY(8'hA2)));
    tick();
    checkOutput("bp_drained",     32'(bus.out_valid), 32'd0);
    checkOutput("bp_credit_load", qAt(load_q, 3),     r + 6);
    repeat (20) tick();
    checkOutput("bp_loads_total", 32'(load_q.size()), 32'd5);
    checkOutput("bp_outs_total",  32'(out_q.size()),  32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput("bp_data", qAt(dat_q, i), 32'(coreY(8'(8'hA0 + i))));
    checkOutput("bp_idle",    32'(busy),    32'd0);
    checkOutput("bp_seq_err", 32'(seq_err), 32'd0);

    $display("[TB] protocol errors");
    resetDut();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    tick();
    checkOutput("err_idle_cv", 32'(seq_err), 32'd1);
    repeat (5) tick();
    checkOutput("err_sticky",      32'(seq_err),       32'd1);
    checkOutput("err_idle_discard", 32'(bus.out_valid), 32'd0);

    resetDut();
    checkOutput("err_cleared", 32'(seq_err), 32'd0);
    clearLogs();
    core_en = 1'b0;
    applyStimulus(8'h5A);
    repeat (10) tick();
    core_en = 1'b1;
    checkOutput("err_miss_loads", 32'(load_q.size()), 32'd1);
    checkOutput("err_miss_flag",  32'(seq_err),       32'd1);
    checkOutput("err_miss_outv",  32'(bus.out_valid), 32'd0);
    checkOutput("err_miss_busy",  32'(busy),          32'd0);

    $display("[TB] reset mid-run");
    resetDut();
    clearLogs();
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h30 + i));
    n = 0;
    while (load_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("mid_second_load", 32'(load_q.size() >= 2), 32'd1);
    l2 = qAt(load_q, 1);
    n  = 0;
    while (cyc < l2 + 2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("mid_level3", 32'(fifo_level), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_in_ready",  32'(bus.in_ready),    32'd0);
    checkOutput("mid_core_load", 32'(bus.core_load),   32'd0);
    checkOutput("mid_sample",    32'(bus.core_sample), 32'd0);
    checkOutput("mid_out_valid", 32'(bus.out_valid),   32'd0);
    checkOutput("mid_out_data",  32'(bus.out_data),    32'd0);
    checkOutput("mid_level",     32'(fifo_level),      32'd0);
    checkOutput("mid_busy",      32'(busy),            32'd0);
    checkOutput("mid_seq_err",   32'(seq_err),         32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    checkOutput("post_level",    32'(fifo_level),    32'd0);
    checkOutput("post_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(bus.in_ready),  32'd1);
    checkOutput("post_seq_err",  32'(seq_err),       32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
